move_select: RTL and testbench
==============================

# move_select

Cursor and move-entry controller for the game screen. It turns debounced key pulses into a cursor position on the 8x8 board, lets the local player pick a source square holding an own piece and then a destination square, and issues the chosen move to the board-update stage over a valid/ready handshake. It reads the current board contents produced by the board stage and drives the `square_highlight` mask consumed by the renderer. Move legality is checked downstream; this block checks only that the source square is owned.

## Interface
- No parameters.
- `CLOCK_50`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `player`  in  1  local colour. 1 means the local player owns codes 0–5; 0 means it owns codes 6–11.
- `my_turn`  in  1  high while the game screen is active and `curr_player == player`.
- `dir`  in  1  cursor axis: 0 moves along the column index, 1 moves along the row index.
- `key1out`  in  1  single-cycle pulse: cursor +1.
- `key2out`  in  1  single-cycle pulse: cursor −1.
- `key3out`  in  1  single-cycle pulse: enter.
- `board_cur`  in  4 [8][8]  current board. 15 means empty.
- `move_ready`  in  1  the board stage accepts the move.
- `move_valid`  out  1  a move is pending.
- `move_from`  out  6  {row[2:0], col[2:0]} of the source square.
- `move_to`  out  6  {row[2:0], col[2:0]} of the destination square.
- `cursor_row`, `cursor_col`  out  3 each  cursor position.
- `square_highlight`  out  1 [8][8]  high at the cursor square and at the latched source square.

## Operation
- **States:** IDLE, PICK_SRC, PICK_DST, ISSUE.
- **Own piece:** `player` = 1 → code ≤ 5. `player` = 0 → 6 ≤ code ≤ 11. Codes 12–15 are never owned.
- **IDLE**
  - Keys are ignored.
  - `my_turn` = 1 → PICK_SRC. The cursor keeps its position.
- **Cursor movement** (PICK_SRC and PICK_DST only)
  - `key1out` adds 1 and `key2out` subtracts 1 on the axis selected by `dir`.
  - Arithmetic is modulo 8: 7+1 = 0 and 0−1 = 7.
  - The other axis is unchanged.
- **Simultaneous key pulses:** enter wins and the cursor does not move. `key1out` and `key2out` together without enter do nothing.
- **PICK_SRC + enter**
  - Cursor on an own piece: latch the source square, then go to PICK_DST.
  - Otherwise: no change.
- **PICK_DST + enter**
  - Cursor equals the source: cancel, clear the source, go to PICK_SRC.
  - Cursor on a different own piece: it becomes the new source; stay in PICK_DST.
  - Otherwise: latch the destination and go to ISSUE.
- **ISSUE**
  - `move_valid` = 1, with `move_from` and `move_to` held stable.
  - `move_valid` && `move_ready` at a clock edge: clear the source and go to IDLE.
  - Keys are ignored.
- **`my_turn` falls**
  - In PICK_SRC or PICK_DST: go to IDLE and clear the source.
  - In ISSUE: the move stays pending until `move_ready`.
- **`square_highlight`:** exactly the cursor bit, plus the source bit while a source is latched. At most two bits are set.

## Timing
- **Reset values**
  - State IDLE.
  - Cursor row 7, col 4.
  - No source latched.
  - `move_valid` = 0.
  - `move_from` = `move_to` = 0.
  - `square_highlight` has only [7][4] set.
- All outputs are registered. Next-state values produce the highlight, so the highlight always matches `cursor_row`/`cursor_col` in the same cycle.
- **Key latency:** a pulse at edge N is visible on the cursor and highlight after edge N.
- **Enter latency in PICK_DST:** `move_valid` rises 1 cycle after the pulse.
- **Handshake**
  - `move_valid` may not depend combinationally on `move_ready`.
  - Once high, `move_valid` stays high with `move_from`/`move_to` unchanged until the accepting edge.
  - `move_valid` falls 1 cycle after acceptance.
  - If `move_ready` is already high, acceptance completes 1 cycle after `move_valid` rises.
- **Board sampling:** `board_cur` is sampled at the enter edge.
- **Reset mid-operation:** asynchronous return to the reset values. A pending move is dropped.

## Test plan
- **Wrap-around:** after reset with `my_turn` = 1 and `dir` = 0, press `key1out` 4 times → cursor (7,0), highlight [7][0] only. Then press `key2out` with `dir` = 1 → cursor (6,0).
- **Source select:** `player` = 1, starting board, cursor (6,4), enter → PICK_DST, highlight [6][4]. Then `dir` = 1, `key2out` twice → cursor (4,4), highlight bits [6][4] and [4][4].
- **Rejected source:** enter on empty (4,4), then on enemy code 11 at (1,0) → state stays PICK_SRC and no source is latched.
- **Issue and handshake:** source (6,4), destination (4,4), `move_ready` held 0 for 5 cycles → `move_valid` = 1, `move_from` = 6'o64, `move_to` = 6'o44, both stable. Raise `move_ready` → `move_valid` = 0 the next cycle, state IDLE.
- **Cancel and reselect:** enter on the source again → PICK_SRC with the source cleared. Enter on another own piece while in PICK_DST → the source moves to it.
- **Abort and simultaneous keys:**
  - Drop `my_turn` in PICK_DST → IDLE, highlight shows the cursor only.
  - `key1out` + `key3out` in the same cycle on an own piece → source latched, cursor unmoved.
  - Assert `reset_n` low during ISSUE → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/move_select.sv
// move_select: cursor and move-entry controller for the 8x8 game board.
// Turns debounced key pulses into a cursor position, lets the local player pick
// an owned source square and then a destination, and offers the move downstream.
//
// Ports:
//   CLOCK_50, reset_n             clock, asynchronous active-low reset
//   player, my_turn               local colour, local player may act
//   dir                           cursor axis (0: column, 1: row)
//   key1out/key2out/key3out       single-cycle pulses: +1, -1, enter
//   board_cur                     current board, [row][col] 4-bit codes, 15 = empty
//   move_valid/move_ready         move handshake to the board-update stage
//   move_from, move_to            {row,col} of the pending move
//   cursor_row, cursor_col        cursor position
//   square_highlight              [row][col] mask: cursor plus latched source
//
// Latency: key pulse at edge N is visible on cursor/highlight after edge N;
// enter on a destination raises move_valid one cycle later.
// Backpressure: move_valid holds with move_from/move_to stable until move_ready.
module move_select (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 player,
  input  logic                 my_turn,
  input  logic                 dir,
  input  logic                 key1out,
  input  logic                 key2out,
  input  logic                 key3out,
  input  logic [7:0][7:0][3:0] board_cur,
  input  logic                 move_ready,
  output logic                 move_valid,
  output logic [5:0]           move_from,
  output logic [5:0]           move_to,
  output logic [2:0]           cursor_row,
  output logic [2:0]           cursor_col,
  output logic [7:0][7:0]      square_highlight
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PICK_SRC = 2'd1,
    S_PICK_DST = 2'd2,
    S_ISSUE    = 2'd3
  } state_t;

  // Only square [7][4] set (bit 7*8+4 = 60).
  localparam logic [7:0][7:0] HL_RESET = 64'h1000_0000_0000_0000;

  // Registered state and outputs
  state_t          r_state;
  logic [2:0]      r_cur_row;
  logic [2:0]      r_cur_col;
  logic            r_src_vld;
  logic [5:0]      r_src;
  logic            r_move_valid;
  logic [5:0]      r_move_from;
  logic [5:0]      r_move_to;
  logic [7:0][7:0] r_highlight;

  // Next-state values
  state_t          w_state_nxt;
  logic [2:0]      w_row_nxt;
  logic [2:0]      w_col_nxt;
  logic            w_src_vld_nxt;
  logic [5:0]      w_src_nxt;
  logic            w_mv_vld_nxt;
  logic [5:0]      w_from_nxt;
  logic [5:0]      w_to_nxt;
  logic [7:0][7:0] w_hl_nxt;

  // Key decode: enter dominates; +1 and -1 together cancel out.
  logic w_enter;
  logic w_inc;
  logic w_dec;

  assign w_enter = key3out;
  assign w_inc   = key1out & ~key2out & ~key3out;
  assign w_dec   = key2out & ~key1out & ~key3out;

  // Ownership of the square under the cursor, sampled at the enter edge.
  logic [5:0] w_cur_sq;
  logic [3:0] w_cur_code;
  logic       w_cur_own;

  assign w_cur_sq   = {r_cur_row, r_cur_col};
  assign w_cur_code = board_cur[r_cur_row][r_cur_col];
  assign w_cur_own  = player ? (w_cur_code <= 4'd5)
                             : ((w_cur_code >= 4'd6) && (w_cur_code <= 4'd11));

  logic w_accept;
  assign w_accept = r_move_valid & move_ready;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_cur_row;
    w_col_nxt     = r_cur_col;
    w_src_vld_nxt = r_src_vld;
    w_src_nxt     = r_src;
    w_mv_vld_nxt  = r_move_valid;
    w_from_nxt    = r_move_from;
    w_to_nxt      = r_move_to;

    case (r_state)
      S_IDLE: begin
        // Keys ignored; cursor keeps its position across turns.
        if (my_turn) begin
          w_state_nxt = S_PICK_SRC;
        end
      end

      S_PICK_SRC, S_PICK_DST: begin
        if (!my_turn) begin
          // Turn taken away mid-entry: abandon the partial move.
          w_state_nxt   = S_IDLE;
          w_src_vld_nxt = 1'b0;
        end else if (w_enter) begin
          if (r_state == S_PICK_SRC) begin
            if (w_cur_own) begin
              w_src_nxt     = w_cur_sq;
              w_src_vld_nxt = 1'b1;
              w_state_nxt   = S_PICK_DST;
            end
          end else begin
            if (w_cur_sq == r_src) begin
              // Entering on the source again cancels the selection.
              w_src_vld_nxt = 1'b0;
              w_state_nxt   = S_PICK_SRC;
            end else if (w_cur_own) begin
              // Another own piece replaces the source.
              w_src_nxt = w_cur_sq;
            end else begin
              w_from_nxt   = r_src;
              w_to_nxt     = w_cur_sq;
              w_mv_vld_nxt = 1'b1;
              w_state_nxt  = S_ISSUE;
            end
          end
        end else if (w_inc) begin
          // 3-bit arithmetic gives the modulo-8 wrap for free.
          if (dir) begin
            w_row_nxt = r_cur_row + 3'd1;
          end else begin
            w_col_nxt = r_cur_col + 3'd1;
          end
        end else if (w_dec) begin
          if (dir) begin
            w_row_nxt = r_cur_row - 3'd1;
          end else begin
            w_col_nxt = r_cur_col - 3'd1;
          end
        end
      end

      S_ISSUE: begin
        // The move survives my_turn falling; only acceptance retires it.
        if (w_accept) begin
          w_mv_vld_nxt  = 1'b0;
          w_src_vld_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Highlight built from next-state values so it lines up with the cursor
  // registers in the same cycle.
  always_comb begin
    w_hl_nxt = '0;
    w_hl_nxt[w_row_nxt][w_col_nxt] = 1'b1;
    if (w_src_vld_nxt) begin
      w_hl_nxt[w_src_nxt[5:3]][w_src_nxt[2:0]] = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cur_row    <= 3'd7;
      r_cur_col    <= 3'd4;
      r_src_vld    <= 1'b0;
      r_src        <= 6'd0;
      r_move_valid <= 1'b0;
      r_move_from  <= 6'd0;
      r_move_to    <= 6'd0;
      r_highlight  <= HL_RESET;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_row    <= w_row_nxt;
      r_cur_col    <= w_col_nxt;
      r_src_vld    <= w_src_vld_nxt;
      r_src        <= w_src_nxt;
      r_move_valid <= w_mv_vld_nxt;
      r_move_from  <= w_from_nxt;
      r_move_to    <= w_to_nxt;
      r_highlight  <= w_hl_nxt;
    end
  end

  assign move_valid       = r_move_valid;
  assign move_from        = r_move_from;
  assign move_to          = r_move_to;
  assign cursor_row       = r_cur_row;
  assign cursor_col       = r_cur_col;
  assign square_highlight = r_highlight;

endmodule

// File: tb/tb_move_select.sv
// tb_move_select: self-checking bench for move_select.
// Directed scenarios plus a randomized run, all compared each cycle against a
// behavioural model of the cursor / source / destination / handshake rules.
module tb_move_select;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset_n;
  logic                 player;
  logic                 my_turn;
  logic                 dir;
  logic                 key1out;
  logic                 key2out;
  logic                 key3out;
  logic [7:0][7:0][3:0] board_cur;
  logic                 move_ready;
  logic                 move_valid;
  logic [5:0]           move_from;
  logic [5:0]           move_to;
  logic [2:0]           cursor_row;
  logic [2:0]           cursor_col;
  logic [7:0][7:0]      square_highlight;

  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  move_select dut (
    .CLOCK_50         (CLOCK_50),
    .reset_n          (reset_n),
    .player           (player),
    .my_turn          (my_turn),
    .dir              (dir),
    .key1out          (key1out),
    .key2out          (key2out),
    .key3out          (key3out),
    .board_cur        (board_cur),
    .move_ready       (move_ready),
    .move_valid       (move_valid),
    .move_from        (move_from),
    .move_to          (move_to),
    .cursor_row       (cursor_row),
    .cursor_col       (cursor_col),
    .square_highlight (square_highlight)
  );

  logic [82:0] obs;
  assign obs = {move_valid, move_from, move_to, cursor_row, cursor_col, square_highlight};

  // ---------------- reference model ----------------
  // phase: 0 waiting for turn, 1 choosing source, 2 choosing destination, 3 offering move
  int       m_phase;
  int       m_row, m_col;
  bit       m_src_vld;
  int       m_sr, m_sc;
  bit       m_valid;
  int       m_from, m_to;

  function automatic bit owns(input int code, input bit pl);
    if (pl) return (code <= 5);
    return (code >= 6 && code <= 11);
  endfunction

  function void model_reset();
    m_phase = 0; m_row = 7; m_col = 4;
    m_src_vld = 0; m_sr = 0; m_sc = 0;
    m_valid = 0; m_from = 0; m_to = 0;
  endfunction

  function void model_step();
    bit enter, up, down, own;
    enter = key3out;
    up    = key1out && !key2out && !key3out;
    down  = key2out && !key1out && !key3out;
    own   = owns(int'(board_cur[m_row][m_col]), player);
    if (m_phase == 0) begin
      if (my_turn) m_phase = 1;
    end else if (m_phase == 3) begin
      if (m_valid && move_ready) begin
        m_valid = 0; m_src_vld = 0; m_phase = 0;
      end
    end else if (!my_turn) begin
      m_phase = 0; m_src_vld = 0;
    end else if (enter) begin
      if (m_phase == 1) begin
        if (own) begin m_sr = m_row; m_sc = m_col; m_src_vld = 1; m_phase = 2; end
      end else if (m_row == m_sr && m_col == m_sc) begin
        m_src_vld = 0; m_phase = 1;
      end else if (own) begin
        m_sr = m_row; m_sc = m_col;
      end else begin
        m_from = m_sr * 8 + m_sc; m_to = m_row * 8 + m_col; m_valid = 1; m_phase = 3;
      end
    end else if (up) begin
      if (dir) m_row = (m_row + 1) % 8; else m_col = (m_col + 1) % 8;
    end else if (down) begin
      if (dir) m_row = (m_row + 7) % 8; else m_col = (m_col + 7) % 8;
    end
  endfunction

  function automatic logic [82:0] exp_vec();
    logic [63:0] hl;
    hl = '0;
    hl[m_row * 8 + m_col] = 1'b1;
    if (m_src_vld) hl[m_sr * 8 + m_sc] = 1'b1;
    return {m_valid, 6'(m_from), 6'(m_to), 3'(m_row), 3'(m_col), hl};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    if (reset_n) model_step();
    @(posedge CLOCK_50);
    #1;
    key1out = 1'b0; key2out = 1'b0; key3out = 1'b0;
  endtask

  // k: 1 = +1, 2 = -1, 3 = enter
  task automatic press(input int k, input bit d);
    dir = d;
    key1out = (k == 1); key2out = (k == 2); key3out = (k == 3);
    tick();
  endtask

  task automatic set_start_board();
    for (int c = 0; c < 8; c++) begin
      board_cur[7][c] = 4'(c % 5);
      board_cur[6][c] = 4'd5;
      board_cur[1][c] = 4'd11;
      board_cur[0][c] = 4'(6 + c % 5);
      for (int r = 2; r < 6; r++) board_cur[r][c] = 4'd15;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; player = 1'b1; my_turn = 1'b0; dir = 1'b0;
    key1out = 0; key2out = 0; key3out = 0; move_ready = 0;
    set_start_board();
    #5;
    model_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs, exp_vec());
    end
    checks++;
    if (square_highlight !== 64'h1000_0000_0000_0000) begin
      errors++; $display("FAIL reset_highlight: got %h want %h", square_highlight, 64'h1000_0000_0000_0000);
    end
  endtask

  task automatic test_wrap();
    my_turn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      press(1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL wrap_step%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (cursor_row !== 3'd7 || cursor_col !== 3'd0 || square_highlight !== 64'h0100_0000_0000_0000) begin
      errors++; $display("FAIL wrap_col: got (%0d,%0d) %h want (7,0) %h", cursor_row, cursor_col, square_highlight, 64'h0100_0000_0000_0000);
    end
    press(2, 1'b1);
    checks++;
    if (cursor_row !== 3'd6 || cursor_col !== 3'd0 || obs !== exp_vec()) begin
      errors++; $display("FAIL wrap_row: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_source_and_issue();
    for (int i = 0; i < 4; i++) press(1, 1'b0);
    press(3, 1'b0);
    checks++;
    if (obs !== exp_vec() || square_highlight !== (64'd1 << 52)) begin
      errors++; $display("FAIL src_select: got %h want %h", obs, exp_vec());
    end
    press(2, 1'b1);
    press(2, 1'b1);
    checks++;
    if (obs !== exp_vec() || square_highlight !== ((64'd1 << 52) | (64'd1 << 36))) begin
      errors++; $display("FAIL src_highlight: got %h want %h", obs, exp_vec());
    end
    press(3, 1'b0);
    checks++;
    if (obs !== exp_vec() || move_valid !== 1'b1) begin
      errors++; $display("FAIL issue_rise: got %h want %h", obs, exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      press(1, 1'b0);
      checks++;
      if (move_valid !== 1'b1 || move_from !== 6'o64 || move_to !== 6'o44 || obs !== exp_vec()) begin
        errors++; $display("FAIL issue_hold%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    checks++;
    if (move_valid !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL issue_accept: got %h want %h", obs, exp_vec());
    end
    press(1, 1'b0);
    checks++;
    if (cursor_col !== 3'd4 || obs !== exp_vec()) begin
      errors++; $display("FAIL idle_keys_ignored: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_rejected();
    press(3, 1'b0);
    checks++;
    if (obs !== exp_vec() || square_highlight !== (64'd1 << 36)) begin
      errors++; $display("FAIL reject_empty: got %h want %h", obs, exp_vec());
    end
    for (int i = 0; i < 3; i++) press(2, 1'b1);
    for (int i = 0; i < 4; i++) press(2, 1'b0);
    press(3, 1'b0);
    checks++;
    if (obs !== exp_vec() || square_highlight !== (64'd1 << 8)) begin
      errors++; $display("FAIL reject_enemy: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_cancel_reselect();
    for (int i = 0; i < 5; i++) press(1, 1'b1);
    for (int i = 0; i < 4; i++) press(1, 1'b0);
    press(3, 1'b0);
    press(3, 1'b0);
    press(1, 1'b0);
    checks++;
    if (obs !== exp_vec() || square_highlight !== (64'd1 << 53)) begin
      errors++; $display("FAIL cancel: got %h want %h", obs, exp_vec());
    end
    press(2, 1'b0);
    press(3, 1'b0);
    press(1, 1'b0);
    press(3, 1'b0);
    press(2, 1'b0);
    checks++;
    if (obs !== exp_vec() || square_highlight !== ((64'd1 << 52) | (64'd1 << 53))) begin
      errors++; $display("FAIL reselect: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_abort_and_simultaneous();
    my_turn = 1'b0;
    tick();
    checks++;
    if (obs !== exp_vec() || square_highlight !== (64'd1 << 52)) begin
      errors++; $display("FAIL abort: got %h want %h", obs, exp_vec());
    end
    my_turn = 1'b1;
    tick();
    dir = 1'b0; key1out = 1'b1; key3out = 1'b1;
    tick();
    checks++;
    if (cursor_col !== 3'd4 || obs !== exp_vec()) begin
      errors++; $display("FAIL simul_keys: got %h want %h", obs, exp_vec());
    end
    press(2, 1'b1);
    press(2, 1'b1);
    checks++;
    if (obs !== exp_vec() || square_highlight !== ((64'd1 << 52) | (64'd1 << 36))) begin
      errors++; $display("FAIL simul_src_latched: got %h want %h", obs, exp_vec());
    end
    press(3, 1'b0);
    my_turn = 1'b0;
    tick();
    checks++;
    if (move_valid !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL issue_survives_turn: got %h want %h", obs, exp_vec());
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== exp_vec() || move_valid !== 1'b0 || square_highlight !== 64'h1000_0000_0000_0000) begin
      errors++; $display("FAIL async_reset: got %h want %h", obs, exp_vec());
    end
    #4;
    reset_n = 1'b1;
    tick();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL post_reset: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      if (n % 60 == 0) begin
        player = 1'($urandom_range(0, 1));
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            board_cur[r][c] = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      end
      my_turn    = ($urandom_range(0, 19) != 0);
      move_ready = ($urandom_range(0, 2) == 0);
      dir        = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2: key1out = 1'b1;
        3, 4, 5: key2out = 1'b1;
        6:       key3out = 1'b1;
        7:       begin key1out = 1'b1; key3out = 1'b1; end
        8:       begin key1out = 1'b1; key2out = 1'b1; end
        default: ;
      endcase
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h want %h", n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wrap();
    test_source_and_issue();
    test_rejected();
    test_cancel_reselect();
    test_abort_and_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
